// File: rtl/stepdown_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stepdown_ctrl_pkg
//  Description : Shared definitions for the step-down switch sequencer.
//                Holds the gate-sequencer state encoding and the default
//                values of the block's size and timing parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
package stepdown_ctrl_pkg;

    // Default period/duty counter width and deadtime field width
    localparam int c_pw_default      = 8;
    localparam int c_dtw_default     = 4;

    // Default OCP blanking length (HS_ON cycles) and fault threshold
    // (consecutive OCP-terminated periods)
    localparam int c_blank_default   = 3;
    localparam int c_ocp_lim_default = 4;

    // Gate sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DT_LH = 3'd1,
        ST_HS_ON = 3'd2,
        ST_DT_HL = 3'd3,
        ST_LS_ON = 3'd4,
        ST_DIODE = 3'd5,
        ST_FAULT = 3'd6
    } state_t;

endpackage : stepdown_ctrl_pkg
`default_nettype wire

// File: rtl/stepdown_dt_timer.sv
`default_nettype none
// ============================================================================
//  Module      : stepdown_dt_timer
//  Description : Loadable saturating down-counter used for deadtime,
//                high-side on-time and OCP blanking intervals.
//                Loading value N makes o_done assert N cycles later and stay
//                asserted until the next load (load 0 -> done next cycle).
//  Ports       : clk        - clock
//                rst        - asynchronous active-high reset
//                i_load     - load i_load_val into the counter
//                i_load_val - interval length minus one
//                i_count    - decrement enable
//                o_done     - counter has reached zero
//  Revision    : 1.0 - initial release
// ============================================================================
module stepdown_dt_timer
    import stepdown_ctrl_pkg::*;
#(
    parameter int W = c_pw_default
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_count,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_count && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule : stepdown_dt_timer
`default_nettype wire

// File: rtl/stepdown_switch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : stepdown_switch_seq
//  Description : Gate sequencer for a synchronous step-down converter.
//                A free-running period counter starts each switching period;
//                the FSM drives deadtime -> high side -> deadtime -> low side,
//                with over-current termination (after blanking), diode
//                emulation on zero-cross, and a latched fault after repeated
//                OCP-terminated periods.
//  Ports       : CELCLK       - clock
//                CELRST       - asynchronous active-high reset
//                CELV/CELG/SUB- supply pins, no logic function
//                en           - converter enable
//                cfg_period   - period length minus one (clocks)
//                cfg_duty     - requested HS on-count
//                cfg_dt       - deadtime (clocks, 0 treated as 1)
//                ocp, zcd     - synchronised comparator inputs
//                hs_on, ls_on - registered gate requests
//                cycle_start  - one-cycle pulse at period start
//                fault        - latched OCP fault
//  Revision    : 1.0 - initial release
// ============================================================================
module stepdown_switch_seq
    import stepdown_ctrl_pkg::*;
#(
    parameter int PW      = c_pw_default,
    parameter int DTW     = c_dtw_default,
    parameter int BLANK   = c_blank_default,
    parameter int OCP_LIM = c_ocp_lim_default
) (
    input  logic           CELCLK,
    input  logic           CELRST,
    input  logic           CELV,
    input  logic           CELG,
    input  logic           SUB,
    input  logic           en,
    input  logic [PW-1:0]  cfg_period,
    input  logic [PW-1:0]  cfg_duty,
    input  logic [DTW-1:0] cfg_dt,
    input  logic           ocp,
    input  logic           zcd,
    output logic           hs_on,
    output logic           ls_on,
    output logic           cycle_start,
    output logic           fault
);

    localparam int TW = (PW > DTW) ? PW : DTW;      // phase timer width
    localparam int BW = $clog2(BLANK + 2);          // blanking timer width
    localparam int RW = $clog2(OCP_LIM + 1);        // ocp_run width
    localparam int SW = PW + DTW + 2;               // signed duty arithmetic

    localparam logic [BW-1:0] c_blank_val  = BW'(BLANK);
    localparam logic [RW-1:0] c_run_last   = RW'(OCP_LIM - 1);

    state_t         r_state;
    state_t         w_next;
    logic [PW-1:0]  r_pcnt;
    logic [PW-1:0]  r_period_l;
    logic [PW-1:0]  r_duty_l;
    logic [DTW-1:0] r_dt_l;
    logic [RW-1:0]  r_ocp_run;
    logic           r_hs;
    logic           r_ls;
    logic           r_cs;
    logic           r_fault;

    logic           w_run;
    logic           w_cs;
    logic [PW-1:0]  w_period_cur;
    logic [DTW-1:0] w_dt_new;
    logic [PW-1:0]  w_duty_new;
    logic signed [SW-1:0] w_room;
    logic signed [SW-1:0] w_duty_req;

    logic           w_ph_load;
    logic [TW-1:0]  w_ph_val;
    logic           w_ph_done;
    logic           w_bl_load;
    logic           w_bl_done;
    logic           w_ocp_inc;
    logic           w_ocp_clr;

    logic           w_unused_pins;

    // Supply/substrate pins carry no logic
    assign w_unused_pins = CELV ^ CELG ^ SUB;

    // ------------------------------------------------------------------
    // Period counter
    // ------------------------------------------------------------------
    assign w_run = en & ~r_fault;
    assign w_cs  = w_run & (r_pcnt == '0);

    // The wrap point is taken from the value latched at period start so a
    // mid-period cfg_period write only affects the following period.
    assign w_period_cur = w_cs ? cfg_period : r_period_l;

    always_ff @(posedge CELCLK or posedge CELRST) begin
        if (CELRST) begin
            r_pcnt     <= '0;
            r_period_l <= '0;
        end else begin
            if (!w_run) begin
                r_pcnt <= '0;
            end else if (r_pcnt >= w_period_cur) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + PW'(1);
            end
            if (w_cs) begin
                r_period_l <= cfg_period;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-period timing snapshot: deadtime of at least one clock, and the
    // HS on-time clamped so both deadtimes still fit inside the period.
    // ------------------------------------------------------------------
    assign w_dt_new   = (cfg_dt == '0) ? DTW'(1) : cfg_dt;
    assign w_room     = $signed({{(SW-PW){1'b0}}, cfg_period})
                      - $signed({{(SW-DTW-1){1'b0}}, w_dt_new, 1'b0});
    assign w_duty_req = $signed({{(SW-PW){1'b0}}, cfg_duty});

    always_comb begin
        w_duty_new = '0;
        if (w_room[SW-1]) begin
            w_duty_new = '0;
        end else if (w_duty_req < w_room) begin
            w_duty_new = cfg_duty;
        end else begin
            w_duty_new = w_room[PW-1:0];
        end
    end

    always_ff @(posedge CELCLK or posedge CELRST) begin
        if (CELRST) begin
            r_dt_l   <= DTW'(1);
            r_duty_l <= '0;
        end else if (w_cs) begin
            r_dt_l   <= w_dt_new;
            r_duty_l <= w_duty_new;
        end
    end

    // ------------------------------------------------------------------
    // Interval timers: one for deadtime/on-time phases, one for blanking
    // ------------------------------------------------------------------
    stepdown_dt_timer #(
        .W (TW)
    ) u_phase (
        .clk        (CELCLK),
        .rst        (CELRST),
        .i_load     (w_ph_load),
        .i_load_val (w_ph_val),
        .i_count    (1'b1),
        .o_done     (w_ph_done)
    );

    stepdown_dt_timer #(
        .W (BW)
    ) u_blank (
        .clk        (CELCLK),
        .rst        (CELRST),
        .i_load     (w_bl_load),
        .i_load_val (c_blank_val),
        .i_count    (1'b1),
        .o_done     (w_bl_done)
    );

    // ------------------------------------------------------------------
    // Sequencer next state. Timers are loaded with (length - 1) on the
    // transition into a timed phase, so the phase lasts exactly 'length'.
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_ph_load = 1'b0;
        w_ph_val  = '0;
        w_bl_load = 1'b0;
        w_ocp_inc = 1'b0;
        w_ocp_clr = 1'b0;

        if (!en) begin
            // Disable overrides every other event in the same cycle
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_LS_ON, ST_DIODE: begin
                    if (w_cs) begin
                        if (w_duty_new != '0) begin
                            w_next    = ST_DT_LH;
                            w_ph_load = 1'b1;
                            w_ph_val  = TW'(w_dt_new - DTW'(1));
                        end else begin
                            w_next = ST_LS_ON;
                        end
                    end else if ((r_state == ST_LS_ON) && zcd) begin
                        w_next = ST_DIODE;
                    end
                end
                ST_DT_LH: begin
                    if (w_ph_done) begin
                        w_next    = ST_HS_ON;
                        w_ph_load = 1'b1;
                        w_ph_val  = TW'(r_duty_l - PW'(1));
                        w_bl_load = 1'b1;
                    end
                end
                ST_HS_ON: begin
                    if (w_ph_done) begin
                        // Full on-time reached: normal termination
                        w_next    = ST_DT_HL;
                        w_ph_load = 1'b1;
                        w_ph_val  = TW'(r_dt_l - DTW'(1));
                        w_ocp_clr = 1'b1;
                    end else if (ocp && w_bl_done) begin
                        w_ocp_inc = 1'b1;
                        if (r_ocp_run >= c_run_last) begin
                            w_next = ST_FAULT;
                        end else begin
                            w_next    = ST_DT_HL;
                            w_ph_load = 1'b1;
                            w_ph_val  = TW'(r_dt_l - DTW'(1));
                        end
                    end
                end
                ST_DT_HL: begin
                    if (w_ph_done) begin
                        w_next = ST_LS_ON;
                    end
                end
                ST_FAULT: begin
                    w_next = ST_FAULT;
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, OCP run counter and registered outputs. Gates are decoded
    // from the next state so they change on the same edge as the state.
    // ------------------------------------------------------------------
    always_ff @(posedge CELCLK or posedge CELRST) begin
        if (CELRST) begin
            r_state   <= ST_IDLE;
            r_ocp_run <= '0;
            r_hs      <= 1'b0;
            r_ls      <= 1'b0;
            r_cs      <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_hs    <= (w_next == ST_HS_ON);
            r_ls    <= (w_next == ST_LS_ON);
            r_fault <= (w_next == ST_FAULT);
            r_cs    <= w_cs;
            if (!en) begin
                r_ocp_run <= '0;
            end else if (w_ocp_inc) begin
                r_ocp_run <= r_ocp_run + RW'(1);
            end else if (w_ocp_clr) begin
                r_ocp_run <= '0;
            end
        end
    end

    assign hs_on       = r_hs;
    assign ls_on       = r_ls;
    assign cycle_start = r_cs;
    assign fault       = r_fault;

endmodule : stepdown_switch_seq
`default_nettype wire

// File: tb/tb_stepdown_switch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stepdown_switch_seq
//  Description : Self-checking bench for stepdown_switch_seq. Expected
//                per-cycle output words {fault, cycle_start, hs_on, ls_on}
//                are queued as stimulus is applied and compared one per
//                clock, sampled 1 time unit after the rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stepdown_switch_seq;

    localparam logic [3:0] c_off = 4'b0000;
    localparam logic [3:0] c_hs  = 4'b0010;
    localparam logic [3:0] c_ls  = 4'b0001;
    localparam logic [3:0] c_cs  = 4'b0100;
    localparam logic [3:0] c_flt = 4'b1000;

    logic       CELCLK = 1'b0;
    logic       CELRST;
    logic       CELV;
    logic       CELG;
    logic       SUB;
    logic       en;
    logic [7:0] cfg_period;
    logic [7:0] cfg_duty;
    logic [3:0] cfg_dt;
    logic       ocp;
    logic       zcd;
    logic       hs_on;
    logic       ls_on;
    logic       cycle_start;
    logic       fault;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc_no = 0;
    string      cur = "init";
    logic [3:0] sb[$];

    stepdown_switch_seq dut (
        .CELCLK      (CELCLK),
        .CELRST      (CELRST),
        .CELV        (CELV),
        .CELG        (CELG),
        .SUB         (SUB),
        .en          (en),
        .cfg_period  (cfg_period),
        .cfg_duty    (cfg_duty),
        .cfg_dt      (cfg_dt),
        .ocp         (ocp),
        .zcd         (zcd),
        .hs_on       (hs_on),
        .ls_on       (ls_on),
        .cycle_start (cycle_start),
        .fault       (fault)
    );

    always #5 CELCLK = ~CELCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Gates must never overlap, in any test
    always @(negedge CELCLK) begin
        chk("no_overlap", 32'(hs_on & ls_on), 32'd0);
        assert (!(hs_on && ls_on)) else $error("gate overlap at %0t", $time);
    end

    task automatic cyc();
        logic [3:0] e;
        @(posedge CELCLK);
        #1;
        cyc_no++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("%s@%0d", cur, cyc_no),
                32'({fault, cycle_start, hs_on, ls_on}), 32'(e));
        end
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    // Expected words for one full period, derived from the configuration
    task automatic push_period(input int p, input int d, input int dt);
        int dte;
        int room;
        int de;
        dte  = (dt == 0) ? 1 : dt;
        room = p - 2 * dte;
        de   = (room < 0) ? 0 : ((d < room) ? d : room);
        if (de > 0) begin
            sb.push_back(c_cs);
            repeat (dte - 1) sb.push_back(c_off);
            repeat (de) sb.push_back(c_hs);
            repeat (dte) sb.push_back(c_off);
            repeat (p + 1 - de - 2 * dte) sb.push_back(c_ls);
        end else begin
            sb.push_back(c_cs | c_ls);
            repeat (p) sb.push_back(c_ls);
        end
    endtask

    // Disable for one cycle, load a new configuration, re-enable
    task automatic restart(input int p, input int d, input int dt);
        en = 1'b0;
        sb.push_back(c_off);
        cyc();
        cfg_period = 8'(p);
        cfg_duty   = 8'(d);
        cfg_dt     = 4'(dt);
        en         = 1'b1;
    endtask

    initial begin
        CELRST = 1'b1; CELV = 1'b1; CELG = 1'b0; SUB = 1'b0;
        en = 1'b0; ocp = 1'b0; zcd = 1'b0;
        cfg_period = 8'd19; cfg_duty = 8'd8; cfg_dt = 4'd2;

        #3;
        chk("rst_hs",    32'(hs_on),       32'd0);
        chk("rst_ls",    32'(ls_on),       32'd0);
        chk("rst_cs",    32'(cycle_start), 32'd0);
        chk("rst_fault", 32'(fault),       32'd0);
        @(posedge CELCLK);
        #1 CELRST = 1'b0;

        // No period starts until enabled
        cur = "idle";
        repeat (3) sb.push_back(c_off);
        run(3);

        // Nominal: 2 off, 8 HS, 2 off, 8 LS, 20-clock period
        cur = "basic";
        en = 1'b1;
        push_period(19, 8, 2);
        push_period(19, 8, 2);
        run(40);

        // Zero deadtime becomes one clock
        cur = "dt0";
        restart(19, 8, 0);
        push_period(19, 8, 0);
        push_period(19, 8, 0);
        run(40);

        // Oversized duty is clamped to period - 2*dt = 15
        cur = "duty_clamp";
        restart(19, 200, 2);
        push_period(19, 200, 2);
        run(20);

        // Zero duty: HS skipped, LS whole period
        cur = "duty0";
        restart(19, 0, 2);
        push_period(19, 0, 2);
        run(20);

        // Short period: room of one clock for HS
        cur = "short";
        restart(5, 4, 2);
        push_period(5, 4, 2);
        push_period(5, 4, 2);
        run(12);

        // Mid-period cfg write only affects the next period
        cur = "cfg_mid";
        restart(19, 8, 2);
        push_period(19, 8, 2);
        push_period(9, 4, 3);
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (i == 5) begin
                cfg_period = 8'd9;
                cfg_duty   = 8'd4;
                cfg_dt     = 4'd3;
            end
        end

        // Zero-cross mid LS: both off until the next period start
        cur = "zcd";
        restart(19, 8, 2);
        push_period(19, 8, 2);
        push_period(19, 8, 2);
        for (int k = 15; k < 20; k++) sb[k] = c_off;
        for (int i = 0; i < 40; i++) begin
            cyc();
            zcd = (i == 14);
        end

        // Enable dropped mid HS: both gates off next edge
        cur = "en_drop";
        restart(19, 8, 2);
        push_period(19, 8, 2);
        run(5);
        en = 1'b0;
        sb.delete();
        sb.push_back(c_off);
        sb.push_back(c_off);
        run(2);

        // Asynchronous reset mid HS
        cur = "rst_mid";
        en = 1'b1;
        push_period(19, 8, 2);
        run(5);
        chk("rst_mid_pre_hs", 32'(hs_on), 32'd1);
        #2 CELRST = 1'b1;
        #1;
        chk("rst_mid_hs", 32'(hs_on),       32'd0);
        chk("rst_mid_ls", 32'(ls_on),       32'd0);
        chk("rst_mid_cs", 32'(cycle_start), 32'd0);
        sb.delete();
        @(posedge CELCLK);
        #1 CELRST = 1'b0;
        cur = "post_rst";
        push_period(19, 8, 2);
        run(20);

        // OCP: cycles 1-2 blanked, cycle 4 terminates; 4th in a row faults
        cur = "ocp";
        restart(19, 8, 2);
        for (int p = 0; p < 3; p++) begin
            sb.push_back(c_cs);
            sb.push_back(c_off);
            repeat (4) sb.push_back(c_hs);
            repeat (2) sb.push_back(c_off);
            repeat (12) sb.push_back(c_ls);
        end
        sb.push_back(c_cs);
        sb.push_back(c_off);
        repeat (4) sb.push_back(c_hs);
        repeat (5) sb.push_back(c_flt);
        for (int i = 0; i < 71; i++) begin
            cyc();
            ocp = (((i % 20) == 2) || ((i % 20) == 3) || ((i % 20) == 5)) && (i < 66);
        end
        ocp = 1'b0;

        // Fault cleared by toggling enable; converter restarts
        cur = "fault_clr";
        en = 1'b0;
        sb.push_back(c_off);
        cyc();
        en = 1'b1;
        push_period(19, 8, 2);
        run(20);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_stepdown_switch_seq
`default_nettype wire
